// File: rtl/ex_alu_arb_pkg.sv
// ex_alu_arb shared types: ALU op codes, request bundle, arbiter sizing.
// Build option EX_ALU_ARB_PRIO_EN selects fixed priority with starve guard.
package ex_alu_arb_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_ARB_REQ_NUM = 2;

  typedef enum logic [2:0] {
    ALU_OP_1_ADD  = 3'd0,
    ALU_OP_1_SLL  = 3'd1,
    ALU_OP_1_SLT  = 3'd2,
    ALU_OP_1_SLTU = 3'd3,
    ALU_OP_1_XOR  = 3'd4,
    ALU_OP_1_SR   = 3'd5,
    ALU_OP_1_OR   = 3'd6,
    ALU_OP_1_AND  = 3'd7
  } alu_op_1_e;

  typedef enum logic [2:0] {
    ALU_COMP_BEQ  = 3'd0,
    ALU_COMP_BNE  = 3'd1,
    ALU_COMP_NONE = 3'd2,
    ALU_COMP_BLT  = 3'd4,
    ALU_COMP_BGE  = 3'd5,
    ALU_COMP_BLTU = 3'd6,
    ALU_COMP_BGEU = 3'd7
  } alu_comp_e;

  typedef struct packed {
    logic [2:0]          comp_sel;
    logic                op_0_sel;
    logic [2:0]          op_1_sel;
    logic [ALU_XLEN-1:0] a_comp;
    logic [ALU_XLEN-1:0] b_comp;
    logic [ALU_XLEN-1:0] a_data;
    logic [ALU_XLEN-1:0] b_data;
  } alu_req_t;

endpackage

// File: rtl/ex_alu_arb_if.sv
// ex_alu_arb request/response bundle for both requesters.
// master = requester side, slave = arbiter side.
interface ex_alu_arb_if #(
  parameter int XLEN = 32
);
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][2:0]      req_comp_sel;
  logic [1:0]           req_op_0_sel;
  logic [1:0][2:0]      req_op_1_sel;
  logic [1:0][XLEN-1:0] req_a_comp;
  logic [1:0][XLEN-1:0] req_b_comp;
  logic [1:0][XLEN-1:0] req_a_data;
  logic [1:0][XLEN-1:0] req_b_data;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [1:0]           rsp_comp;
  logic [1:0][XLEN-1:0] rsp_data;

  modport master (
    output req_valid, req_comp_sel,
    output req_op_0_sel, req_op_1_sel,
    output req_a_comp, req_b_comp,
    output req_a_data, req_b_data,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_comp, rsp_data
  );

  modport slave (
    input  req_valid, req_comp_sel,
    input  req_op_0_sel, req_op_1_sel,
    input  req_a_comp, req_b_comp,
    input  req_a_data, req_b_data,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_comp, rsp_data
  );
endinterface

// File: rtl/ex_alu_arb_sel.sv
// ex_alu_arb grant logic: round-robin, or fixed priority with a
// starve counter when EX_ALU_ARB_PRIO_EN is defined.
module ex_alu_arb_sel #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] elig_i,
  output logic [1:0] grant_o
);

  if (STARVE_MAX < 1) begin : g_bad_cfg
    $error("ex_alu_arb_sel: STARVE_MAX must be >= 1");
  end

`ifdef EX_ALU_ARB_PRIO_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q;

  // requester 0 wins unless requester 1 has starved long enough
  always_comb begin
    grant_o = 2'b00;
    if (elig_i[1] && (starve_q == SMAX)) begin
      grant_o = 2'b10;
    end else if (elig_i[0]) begin
      grant_o = 2'b01;
    end else if (elig_i[1]) begin
      grant_o = 2'b10;
    end
  end

  // saturating count of requester-1 losses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q <= '0;
    end else if (grant_o[1] || !elig_i[1]) begin
      starve_q <= '0;
    end else if (starve_q != SMAX) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  logic last_q;

  // on contention favour the requester that did not win last
  always_comb begin
    if (&elig_i) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end else begin
      grant_o = elig_i;
    end
  end

  // pointer moves only when someone is granted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else if (|grant_o) begin
      last_q <= grant_o[1];
    end
  end
`endif

endmodule

// File: rtl/ex_alu_arb.sv
// ex_alu_arb: shares the execute ALU between issue and aux requesters.
// Build option EX_ALU_ARB_PRIO_EN: fixed priority with starve guard.
module ex_alu_arb
  import ex_alu_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0][2:0]      req_comp_sel_i,
  input  logic [1:0]           req_op_0_sel_i,
  input  logic [1:0][2:0]      req_op_1_sel_i,
  input  logic [1:0][XLEN-1:0] req_a_comp_i,
  input  logic [1:0][XLEN-1:0] req_b_comp_i,
  input  logic [1:0][XLEN-1:0] req_a_data_i,
  input  logic [1:0][XLEN-1:0] req_b_data_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [1:0]           rsp_comp_o,
  output logic [1:0][XLEN-1:0] rsp_data_o,
  output logic [2:0]           alu_comp_sel_o,
  output logic                 alu_op_0_sel_o,
  output logic [2:0]           alu_op_1_sel_o,
  output logic [XLEN-1:0]      alu_a_comp_o,
  output logic [XLEN-1:0]      alu_b_comp_o,
  output logic [XLEN-1:0]      alu_a_data_o,
  output logic [XLEN-1:0]      alu_b_data_o,
  input  logic                 alu_comp_i,
  input  logic [XLEN-1:0]      alu_data_i,
  output logic [1:0]           grant_o
);

  alu_req_t             req [ALU_ARB_REQ_NUM];
  alu_req_t             sel_req;
  logic [1:0]           elig;
  logic [1:0]           grant;
  logic [1:0]           rsp_valid_q;
  logic [1:0]           rsp_comp_q;
  logic [1:0][XLEN-1:0] rsp_data_q;

  // slot free or draining, and never while reset is held
  assign elig = req_valid_i
              & (~rsp_valid_q | rsp_ready_i)
              & {2{rst_n_i}};

  ex_alu_arb_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .elig_i  (elig),
    .grant_o (grant)
  );

  assign grant_o     = grant;
  assign req_ready_o = grant;

  // bundle each requester's fields
  always_comb begin
    for (int i = 0; i < ALU_ARB_REQ_NUM; i++) begin
      req[i].comp_sel = req_comp_sel_i[i];
      req[i].op_0_sel = req_op_0_sel_i[i];
      req[i].op_1_sel = req_op_1_sel_i[i];
      req[i].a_comp   = req_a_comp_i[i];
      req[i].b_comp   = req_b_comp_i[i];
      req[i].a_data   = req_a_data_i[i];
      req[i].b_data   = req_b_data_i[i];
    end
  end

  // granted request to the ALU; quiet ADD 0+0 when idle
  always_comb begin
    sel_req          = '0;
    sel_req.comp_sel = ALU_COMP_NONE;
    sel_req.op_1_sel = ALU_OP_1_ADD;
    unique case (1'b1)
      grant[0]: sel_req = req[0];
      grant[1]: sel_req = req[1];
      default:  ;
    endcase
  end

  assign alu_comp_sel_o = sel_req.comp_sel;
  assign alu_op_0_sel_o = sel_req.op_0_sel;
  assign alu_op_1_sel_o = sel_req.op_1_sel;
  assign alu_a_comp_o   = sel_req.a_comp;
  assign alu_b_comp_o   = sel_req.b_comp;
  assign alu_a_data_o   = sel_req.a_data;
  assign alu_b_data_o   = sel_req.b_data;

  // one-entry response slot per requester
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_q <= '0;
      rsp_comp_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      for (int i = 0; i < ALU_ARB_REQ_NUM; i++) begin
        if (grant[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_comp_q[i]  <= alu_comp_i;
          rsp_data_q[i]  <= alu_data_i;
        end else if (rsp_ready_i[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_comp_o  = rsp_comp_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_ex_alu_arb.sv
// Directed bench for ex_alu_arb with a behavioural ALU.
// Define EX_ALU_ARB_PRIO_EN to exercise the priority build.
module tb_ex_alu_arb;
  import ex_alu_arb_pkg::*;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  ex_alu_arb_if #(.XLEN(XLEN)) bus ();

  logic [2:0]      alu_comp_sel;
  logic            alu_op_0_sel;
  logic [2:0]      alu_op_1_sel;
  logic [XLEN-1:0] alu_a_comp;
  logic [XLEN-1:0] alu_b_comp;
  logic [XLEN-1:0] alu_a_data;
  logic [XLEN-1:0] alu_b_data;
  logic            alu_comp;
  logic [XLEN-1:0] alu_data;
  logic [1:0]      grant;

  ex_alu_arb #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (bus.req_valid),
    .req_ready_o    (bus.req_ready),
    .req_comp_sel_i (bus.req_comp_sel),
    .req_op_0_sel_i (bus.req_op_0_sel),
    .req_op_1_sel_i (bus.req_op_1_sel),
    .req_a_comp_i   (bus.req_a_comp),
    .req_b_comp_i   (bus.req_b_comp),
    .req_a_data_i   (bus.req_a_data),
    .req_b_data_i   (bus.req_b_data),
    .rsp_valid_o    (bus.rsp_valid),
    .rsp_ready_i    (bus.rsp_ready),
    .rsp_comp_o     (bus.rsp_comp),
    .rsp_data_o     (bus.rsp_data),
    .alu_comp_sel_o (alu_comp_sel),
    .alu_op_0_sel_o (alu_op_0_sel),
    .alu_op_1_sel_o (alu_op_1_sel),
    .alu_a_comp_o   (alu_a_comp),
    .alu_b_comp_o   (alu_b_comp),
    .alu_a_data_o   (alu_a_data),
    .alu_b_data_o   (alu_b_data),
    .alu_comp_i     (alu_comp),
    .alu_data_i     (alu_data),
    .grant_o        (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU
  always_comb begin
    alu_data = '0;
    alu_comp = 1'b0;
    case (alu_op_1_sel)
      ALU_OP_1_ADD:  alu_data = alu_op_0_sel ? alu_a_data - alu_b_data
                                             : alu_a_data + alu_b_data;
      ALU_OP_1_SLL:  alu_data = alu_a_data << alu_b_data[4:0];
      ALU_OP_1_SLT:  alu_data = {31'd0, $signed(alu_a_data) < $signed(alu_b_data)};
      ALU_OP_1_SLTU: alu_data = {31'd0, alu_a_data < alu_b_data};
      ALU_OP_1_XOR:  alu_data = alu_a_data ^ alu_b_data;
      ALU_OP_1_SR:   alu_data = alu_op_0_sel ? XLEN'($signed(alu_a_data) >>> alu_b_data[4:0])
                                             : alu_a_data >> alu_b_data[4:0];
      ALU_OP_1_OR:   alu_data = alu_a_data | alu_b_data;
      default:       alu_data = alu_a_data & alu_b_data;
    endcase
    case (alu_comp_sel)
      ALU_COMP_BEQ:  alu_comp = alu_a_comp == alu_b_comp;
      ALU_COMP_BNE:  alu_comp = alu_a_comp != alu_b_comp;
      ALU_COMP_BLT:  alu_comp = $signed(alu_a_comp) < $signed(alu_b_comp);
      ALU_COMP_BGE:  alu_comp = $signed(alu_a_comp) >= $signed(alu_b_comp);
      ALU_COMP_BLTU: alu_comp = alu_a_comp < alu_b_comp;
      ALU_COMP_BGEU: alu_comp = alu_a_comp >= alu_b_comp;
      default:       alu_comp = 1'b0;
    endcase
  end

  task automatic drive_req(input int r, input logic [2:0] cs,
                           input logic o0, input logic [2:0] o1,
                           input logic [31:0] ac, input logic [31:0] bc,
                           input logic [31:0] ad, input logic [31:0] bd);
    bus.req_comp_sel[r] = cs;
    bus.req_op_0_sel[r] = o0;
    bus.req_op_1_sel[r] = o1;
    bus.req_a_comp[r]   = ac;
    bus.req_b_comp[r]   = bc;
    bus.req_a_data[r]   = ad;
    bus.req_b_data[r]   = bd;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 2'b00)
      $display("FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (grant !== 2'b00 || bus.req_ready !== 2'b00)
      $display("FAIL reset_grant got %b/%b exp 00", grant, bus.req_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_data !== 64'd0 || bus.rsp_comp !== 2'b00)
      $display("FAIL reset_rsp_data got %h/%b exp 0", bus.rsp_data, bus.rsp_comp);
    else pass_cnt++;
    total_cnt++;
    if (alu_comp_sel !== ALU_COMP_NONE || alu_op_1_sel !== ALU_OP_1_ADD ||
        alu_op_0_sel !== 1'b0 || alu_a_data !== 32'd0 || alu_b_comp !== 32'd0)
      $display("FAIL reset_alu_idle got %h %h %b exp 2 0 0",
               alu_comp_sel, alu_op_1_sel, alu_op_0_sel);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_req(0, ALU_COMP_NONE, 1'b0, ALU_OP_1_ADD, 0, 0, 5, 7);
    bus.req_valid = 2'b01;
    #1;
    total_cnt++;
    if (grant !== 2'b01 || bus.req_ready !== 2'b01)
      $display("FAIL single_grant got %b/%b exp 01", grant, bus.req_ready);
    else pass_cnt++;
    total_cnt++;
    if (alu_a_data !== 32'd5 || alu_b_data !== 32'd7)
      $display("FAIL single_alu_drive got %0d %0d exp 5 7", alu_a_data, alu_b_data);
    else pass_cnt++;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    total_cnt++;
    if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0] !== 32'd12)
      $display("FAIL single_rsp got %b %0d exp 1 12", bus.rsp_valid[0], bus.rsp_data[0]);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (grant !== 2'b00 || alu_comp_sel !== ALU_COMP_NONE || alu_a_data !== 32'd0)
      $display("FAIL single_idle got %b %h %h exp 00 2 0", grant, alu_comp_sel, alu_a_data);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 2'b00)
      $display("FAIL single_drain got %b exp 00", bus.rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_req(0, ALU_COMP_NONE, 1'b0, ALU_OP_1_ADD, 0, 0, 1, 1);
    bus.req_valid = 2'b01;
    #1;
    total_cnt++;
    if (grant !== 2'b01)
      $display("FAIL rstmid_grant got %b exp 01", grant);
    else pass_cnt++;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_data[0] !== 32'd0)
      $display("FAIL rstmid_clear got %b %h exp 00 0", bus.rsp_valid, bus.rsp_data[0]);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 2'b00)
      $display("FAIL rstmid_no_rsp got %b exp 00", bus.rsp_valid);
    else pass_cnt++;
  endtask

`ifndef EX_ALU_ARB_PRIO_EN
  task automatic test_contention();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_req(0, ALU_COMP_NONE, 1'b1, ALU_OP_1_ADD, 0, 0, 3, 5);
      drive_req(1, ALU_COMP_NONE, 1'b0, ALU_OP_1_SLTU, 0, 0, 3, 5);
      bus.req_valid = 2'b11;
      #1;
      total_cnt++;
      if (grant !== exp_g[k])
        $display("FAIL rr_grant[%0d] got %b exp %b", k, grant, exp_g[k]);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (exp_g[k] == 2'b01) begin
        if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0] !== 32'hFFFF_FFFE)
          $display("FAIL rr_sub[%0d] got %h exp fffffffe", k, bus.rsp_data[0]);
        else pass_cnt++;
      end else begin
        if (bus.rsp_valid[1] !== 1'b1 || bus.rsp_data[1] !== 32'd1)
          $display("FAIL rr_sltu[%0d] got %h exp 1", k, bus.rsp_data[1]);
        else pass_cnt++;
      end
    end
    idle(2);
  endtask
`else
  task automatic test_prio();
    logic [1:0] exp_g;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive_req(0, ALU_COMP_NONE, 1'b0, ALU_OP_1_ADD, 0, 0, k, 1);
      drive_req(1, ALU_COMP_NONE, 1'b0, ALU_OP_1_OR, 0, 0, k, 32'h100);
      bus.req_valid = 2'b11;
      exp_g = (k % 5 == 4) ? 2'b10 : 2'b01;
      #1;
      total_cnt++;
      if (grant !== exp_g)
        $display("FAIL prio_grant[%0d] got %b exp %b", k, grant, exp_g);
      else pass_cnt++;
    end
    idle(2);
  endtask
`endif

  task automatic test_backpressure();
    idle(2);
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    drive_req(0, ALU_COMP_NONE, 1'b0, ALU_OP_1_ADD, 0, 0, 10, 20);
    drive_req(1, ALU_COMP_NONE, 1'b0, ALU_OP_1_ADD, 0, 0, 1, 2);
    bus.req_valid = 2'b11;
    #1;
    total_cnt++;
    if (grant !== 2'b01)
      $display("FAIL bp_first_grant got %b exp 01", grant);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0] !== 32'd30)
      $display("FAIL bp_first_rsp got %b %0d exp 1 30", bus.rsp_valid[0], bus.rsp_data[0]);
    else pass_cnt++;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive_req(0, ALU_COMP_NONE, 1'b0, ALU_OP_1_ADD, 0, 0, 100, j);
      drive_req(1, ALU_COMP_NONE, 1'b0, ALU_OP_1_ADD, 0, 0, j, 40);
      #1;
      total_cnt++;
      if (grant !== 2'b10 || bus.req_ready[0] !== 1'b0)
        $display("FAIL bp_grant[%0d] got %b/%b exp 10", j, grant, bus.req_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0] !== 32'd30)
        $display("FAIL bp_hold[%0d] got %b %0d exp 1 30", j, bus.rsp_valid[0], bus.rsp_data[0]);
      else pass_cnt++;
      total_cnt++;
      if (bus.rsp_data[1] !== 32'(j + 40))
        $display("FAIL bp_req1[%0d] got %0d exp %0d", j, bus.rsp_data[1], j + 40);
      else pass_cnt++;
    end
  endtask

  task automatic test_drain_refill();
    @(negedge clk);
    bus.rsp_ready = 2'b11;
    drive_req(0, ALU_COMP_BEQ, 1'b0, ALU_OP_1_ADD, 9, 9, 0, 0);
    bus.req_valid = 2'b01;
    #1;
    total_cnt++;
    if (grant !== 2'b01 || bus.req_ready !== 2'b01)
      $display("FAIL dr_grant got %b/%b exp 01", grant, bus.req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_comp[0] !== 1'b1 || bus.rsp_data[0] !== 32'd0)
      $display("FAIL dr_beq got %b %b %0d exp 1 1 0",
               bus.rsp_valid[0], bus.rsp_comp[0], bus.rsp_data[0]);
    else pass_cnt++;
    @(negedge clk);
    drive_req(0, ALU_COMP_BNE, 1'b0, ALU_OP_1_ADD, 9, 9, 2, 3);
    #1;
    total_cnt++;
    if (grant !== 2'b01)
      $display("FAIL dr_grant2 got %b exp 01", grant);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_comp[0] !== 1'b0 || bus.rsp_data[0] !== 32'd5)
      $display("FAIL dr_bne got %b %b %0d exp 1 0 5",
               bus.rsp_valid[0], bus.rsp_comp[0], bus.rsp_data[0]);
    else pass_cnt++;
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.rsp_valid !== 2'b00)
      $display("FAIL dr_final_drain got %b exp 00", bus.rsp_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    drive_req(0, 3'd0, 1'b0, 3'd0, 0, 0, 0, 0);
    drive_req(1, 3'd0, 1'b0, 3'd0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_reset_mid();
`ifndef EX_ALU_ARB_PRIO_EN
    test_contention();
`else
    test_prio();
`endif
    test_backpressure();
    test_drain_refill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_alu_arb.md
Name: ex_alu_arb

Overview:
- Shares the single execute-stage ALU between two requesters:
  - requester 0: main pipeline issue.
  - requester 1: auxiliary unit, e.g. address generation or iterative MDU helper.
- Per-requester valid/ready request channel and a one-entry registered response buffer.
- Drives the ALU select/operand inputs combinationally from the granted request and captures the ALU result at the next clock edge.
- Sits between the issue logic and the ALU, inside the execute stage.

Parameters:
- XLEN, 32, datapath width.
- STARVE_MAX, 4, consecutive requester-1 losses tolerated before a forced grant (only used with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  [1:0]  request valid per requester.
- req_ready_o  out  [1:0]  request accepted this cycle when valid&ready.
- req_comp_sel_i  in  [1:0][2:0]  comparison select per requester.
- req_op_0_sel_i  in  [1:0]  sub/sra modifier per requester.
- req_op_1_sel_i  in  [1:0][2:0]  operation select per requester.
- req_a_comp_i, req_b_comp_i  in  [1:0][XLEN-1:0]  compare operands.
- req_a_data_i, req_b_data_i  in  [1:0][XLEN-1:0]  data operands.
- rsp_valid_o  out  [1:0]  response buffer full.
- rsp_ready_i  in  [1:0]  response consumed when valid&ready.
- rsp_comp_o  out  [1:0]  registered comparison result.
- rsp_data_o  out  [1:0][XLEN-1:0]  registered data result.
- alu_comp_sel_o, alu_op_0_sel_o, alu_op_1_sel_o, alu_a_comp_o, alu_b_comp_o, alu_a_data_o, alu_b_data_o  out  to the ALU; widths match the request fields.
- alu_comp_i  in  1  ALU comparison result.
- alu_data_i  in  XLEN  ALU data result.
- grant_o  out  [1:0]  one-hot grant this cycle; 0 when idle.

Behaviour:
- Eligibility: requester i is eligible when req_valid_i[i] is high and its response slot is free or being drained this cycle (rsp_valid_o[i]==0, or rsp_ready_i[i]==1).
- At most one grant per cycle. req_ready_o = grant_o, and it depends combinationally on req_valid_i.
- Arbitration, default build: round-robin.
  - pointer last_q (1 bit, reset 1, so requester 0 wins the first contention).
  - On contention, grant the requester != last_q.
  - A single eligible requester is granted regardless of the pointer.
  - last_q updates only on a grant.
- ALU drive:
  - Granted request fields pass combinationally to the alu_* outputs.
  - With no grant, drive comp_sel = ALU_COMP_NONE (any non-branch code giving comp 0), op_1_sel = ALU_OP_1_ADD, op_0_sel = 0, operands = 0. This holds ALU outputs stable and low-toggle.
- Capture:
  - At the clock edge after a grant, rsp_data_o[i] <= alu_data_i and rsp_comp_o[i] <= alu_comp_i; rsp_valid_o[i] <= 1.
  - Request-to-response latency is 1 cycle.
- Drain: rsp_valid & rsp_ready with no new grant to the same requester clears rsp_valid.
- Drain and refill in the same cycle keeps rsp_valid at 1 with the new data. This sustains one op per cycle per requester.
- Response data is held stable while rsp_valid=1 and rsp_ready=0.
- Reset (asynchronous, rsp_n_i low):
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_comp_o = 0, last_q = 1, starve counter = 0.
  - Combinational outputs follow: grant_o = 0, req_ready_o = 0.
  - An in-flight result is discarded. Requesters must reissue after reset.
- No internal FSM beyond the pointer, the per-requester slot flags and the starve counter. The effective per-slot states are EMPTY and FULL:
  - EMPTY to FULL on grant.
  - FULL to EMPTY on drain without refill.
  - FULL to FULL on drain with refill.

Optional Feature:
- Macro: EX_ALU_ARB_PRIO_EN.
- Defined: requester 0 has fixed priority. A saturating counter starve_q (width clog2(STARVE_MAX+1)) counts cycles in which requester 1 is eligible but not granted.
  - When starve_q == STARVE_MAX and both are eligible, requester 1 is granted.
  - starve_q clears on any requester-1 grant, or when requester 1 is not eligible.
  - last_q is unused.
- Undefined: round-robin as above; no counter is built.

Decomposition:
- Add to the shared alu_op_enum package:
  - ALU_ARB_REQ_NUM = 2.
  - Packed struct alu_req_t holding comp_sel, op_0_sel, op_1_sel and the four operands.
  - ALU_COMP_NONE idle code.
- One natural sub-module, ex_alu_arb_sel: grant logic (round-robin or priority/starve) taking eligibility and producing a one-hot grant and pointer/counter state.
- Datapath muxing and response buffers stay in ex_alu_arb.

Test Plan:
- Reset mid-capture: assert rst_n_i low in the cycle after a grant -> rsp_valid_o = 00 immediately; after release, no response appears until a new request is granted.
- Single op: req 0 ADD a=5 b=7 -> grant_o = 01 that cycle; next cycle rsp_valid_o[0] = 1, rsp_data_o[0] = 12.
- Contention, round-robin build: both valid every cycle, both rsp_ready = 1 -> grants alternate 01,10,01,10; req0 SUB 3-5 gives 0xFFFFFFFE; req1 SLTU 3<5 gives 1.
- Backpressure: rsp_ready_i[0] = 0 with rsp_valid_o[0] = 1 -> req_ready_o[0] = 0; rsp_data_o[0] holds; req1 (if valid) still granted every cycle.
- Drain and refill: rsp_ready_i[0] = 1 and a new req0 BEQ 9==9 in the same cycle -> rsp_valid_o[0] stays 1; rsp_comp_o[0] = 1 next cycle; no bubble.
- EX_ALU_ARB_PRIO_EN, STARVE_MAX = 4, both always valid -> grant pattern 01,01,01,01,10 repeating.
